// File: rtl/itlb_ptw.sv
// rtl/itlb_ptw.sv - two-level ITLB page-table walker, one walk in flight
// Define PTW_CACHE_EN to add a one-entry last-translation cache.
module itlb_ptw #(
  parameter int XLEN = 32,
  parameter int VPN_BITS = 20,
  parameter int PPN_BITS = 20,
  parameter int LINE_ADDR_BITS = 28,
  parameter logic [LINE_ADDR_BITS-1:0] PT_ROOT_LINE = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      walk_req_valid,
  output logic                      walk_req_ready,
  input  logic [VPN_BITS-1:0]       walk_req_vpn,
  input  logic                      walk_req_admin,
  input  logic                      walk_flush,
  output logic                      walk_resp_valid,
  output logic [PPN_BITS-1:0]       walk_resp_ppn,
  output logic                      walk_resp_admin,
  output logic                      walk_resp_fault,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [LINE_ADDR_BITS-1:0] mem_req_line,
  input  logic                      mem_resp_valid,
  input  logic [4*XLEN-1:0]         mem_resp_data
);
  typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, DONE, DRAIN} state_t;

  state_t                    state;
  logic [VPN_BITS-1:0]       vpn;
  logic                      req_admin;
  logic                      ready_q;
  logic                      mem_req_q;
  logic                      resp_q;
  logic [XLEN-1:0]           words [4];
  logic [1:0]                word_sel;
  logic [XLEN-1:0]           pte;
  logic [LINE_ADDR_BITS-1:0] l1_line;
  logic [LINE_ADDR_BITS-1:0] l2_line;
  logic                      leaf_fault;
  logic                      unused_bits;

  for (genvar k = 0; k < 4; k++) begin : g_word
    assign words[k] = mem_resp_data[k*XLEN +: XLEN];
  end

  assign word_sel   = (state == L1_WAIT) ? vpn[11:10] : vpn[1:0];
  assign pte        = words[word_sel];
  assign l1_line    = PT_ROOT_LINE + LINE_ADDR_BITS'(walk_req_vpn[19:12]);
  assign l2_line    = LINE_ADDR_BITS'({pte[XLEN-1:XLEN-PPN_BITS], vpn[9:2]});
  assign leaf_fault = !pte[0] || (pte[1] && !req_admin);
  assign unused_bits = ^{vpn[19:12], pte[11:2]};

  // A flush this cycle hides the handshakes so no orphan read or stale result escapes.
  assign walk_req_ready  = ready_q && !walk_flush;
  assign mem_req_valid   = mem_req_q && !walk_flush;
  assign walk_resp_valid = resp_q && !walk_flush;

`ifdef PTW_CACHE_EN
  logic                c_valid;
  logic [VPN_BITS-1:0] c_vpn;
  logic [PPN_BITS-1:0] c_ppn;
  logic                c_admin;
  logic                hit;
  logic                hit_fault;
  assign hit       = c_valid && (c_vpn == walk_req_vpn);
  assign hit_fault = c_admin && !walk_req_admin;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      vpn             <= '0;
      req_admin       <= 1'b0;
      ready_q         <= 1'b1;
      mem_req_q       <= 1'b0;
      resp_q          <= 1'b0;
      mem_req_line    <= '0;
      walk_resp_ppn   <= '0;
      walk_resp_admin <= 1'b0;
      walk_resp_fault <= 1'b0;
`ifdef PTW_CACHE_EN
      c_valid         <= 1'b0;
      c_vpn           <= '0;
      c_ppn           <= '0;
      c_admin         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (walk_req_valid && !walk_flush) begin
            vpn       <= walk_req_vpn;
            req_admin <= walk_req_admin;
            ready_q   <= 1'b0;
`ifdef PTW_CACHE_EN
            if (hit) begin
              state           <= DONE;
              resp_q          <= 1'b1;
              walk_resp_fault <= hit_fault;
              walk_resp_ppn   <= hit_fault ? '0 : c_ppn;
              walk_resp_admin <= c_admin;
            end else begin
              state        <= L1_REQ;
              mem_req_q    <= 1'b1;
              mem_req_line <= l1_line;
            end
`else
            state        <= L1_REQ;
            mem_req_q    <= 1'b1;
            mem_req_line <= l1_line;
`endif
          end
        end
        L1_REQ, L2_REQ: begin
          if (walk_flush) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
            ready_q   <= 1'b1;
          end else if (mem_req_ready) begin
            mem_req_q <= 1'b0;
            state     <= (state == L1_REQ) ? L1_WAIT : L2_WAIT;
          end
        end
        L1_WAIT: begin
          if (mem_resp_valid) begin
            if (walk_flush) begin
              state   <= IDLE;
              ready_q <= 1'b1;
            end else if (!pte[0]) begin
              state           <= DONE;
              resp_q          <= 1'b1;
              walk_resp_ppn   <= '0;
              walk_resp_admin <= 1'b0;
              walk_resp_fault <= 1'b1;
            end else begin
              state        <= L2_REQ;
              mem_req_q    <= 1'b1;
              mem_req_line <= l2_line;
            end
          end else if (walk_flush) begin
            state <= DRAIN;
          end
        end
        L2_WAIT: begin
          if (mem_resp_valid) begin
            if (walk_flush) begin
              state   <= IDLE;
              ready_q <= 1'b1;
            end else begin
              state           <= DONE;
              resp_q          <= 1'b1;
              walk_resp_ppn   <= leaf_fault ? '0 : pte[XLEN-1:XLEN-PPN_BITS];
              walk_resp_admin <= pte[1];
              walk_resp_fault <= leaf_fault;
`ifdef PTW_CACHE_EN
              if (!leaf_fault) begin
                c_valid <= 1'b1;
                c_vpn   <= vpn;
                c_ppn   <= pte[XLEN-1:XLEN-PPN_BITS];
                c_admin <= pte[1];
              end
`endif
            end
          end else if (walk_flush) begin
            state <= DRAIN;
          end
        end
        DONE: begin
          state   <= IDLE;
          resp_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        DRAIN: begin
          if (mem_resp_valid) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          ready_q   <= 1'b1;
          mem_req_q <= 1'b0;
          resp_q    <= 1'b0;
        end
      endcase
`ifdef PTW_CACHE_EN
      if (walk_flush) c_valid <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_itlb_ptw.sv
// tb/tb_itlb_ptw.sv - directed bench for itlb_ptw with a line-memory model
module tb_itlb_ptw;
  logic         clk = 1'b0;
  logic         rst;
  logic         walk_req_valid;
  logic         walk_req_ready;
  logic [19:0]  walk_req_vpn;
  logic         walk_req_admin;
  logic         walk_flush;
  logic         walk_resp_valid;
  logic [19:0]  walk_resp_ppn;
  logic         walk_resp_admin;
  logic         walk_resp_fault;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [27:0]  mem_req_line;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  always #5 clk = ~clk;

  itlb_ptw dut (
    .clk(clk), .rst(rst),
    .walk_req_valid(walk_req_valid), .walk_req_ready(walk_req_ready),
    .walk_req_vpn(walk_req_vpn), .walk_req_admin(walk_req_admin), .walk_flush(walk_flush),
    .walk_resp_valid(walk_resp_valid), .walk_resp_ppn(walk_resp_ppn),
    .walk_resp_admin(walk_resp_admin), .walk_resp_fault(walk_resp_fault),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_line(mem_req_line),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // memory model: ready after 'stall' offered cycles, response 'lat' cycles after accept
  logic [127:0] mem_lines [logic [27:0]];
  int           stall = 0;
  int           lat = 1;
  int           pend = 0;
  int           req_count = 0;
  logic [27:0]  pend_line;

  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_resp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_lines.exists(pend_line) ? mem_lines[pend_line] : '0;
        end
      end
      mem_req_ready = 1'b0;
      if (mem_req_valid && pend == 0) begin
        if (stall > 0) stall--;
        else begin
          mem_req_ready = 1'b1;
          pend          = lat;
          pend_line     = mem_req_line;
          req_count++;
        end
      end
    end
  end

  int          r_t;
  int          r_reads;
  logic [19:0] r_ppn;
  logic        r_fault;
  logic        r_admin;
  logic [27:0] lines_seen [$];

  task automatic do_walk(input logic [19:0] v, input logic adm);
    int base;
    base = req_count;
    @(posedge clk); #1;
    walk_req_valid = 1'b1;
    walk_req_vpn   = v;
    walk_req_admin = adm;
    @(posedge clk); #1;
    walk_req_valid = 1'b0;
    r_t = -1;
    lines_seen.delete();
    for (int n = 1; n <= 40 && r_t < 0; n++) begin
      @(negedge clk);
      if (mem_req_valid) lines_seen.push_back(mem_req_line);
      if (walk_resp_valid) begin
        r_t     = n;
        r_ppn   = walk_resp_ppn;
        r_fault = walk_resp_fault;
        r_admin = walk_resp_admin;
      end
    end
    repeat (2) @(posedge clk);
    r_reads = req_count - base;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int seen;
    rst = 1'b0;
    walk_req_valid = 1'b0;
    walk_req_vpn = '0;
    walk_req_admin = 1'b0;
    walk_flush = 1'b0;
    mem_lines[28'h0000000] = {32'h0, 32'h0, 32'h00020001, 32'h0};
    mem_lines[28'h0002000] = {32'h12345001, 32'h0, 32'h0, 32'h0};
    mem_lines[28'h0000001] = {32'h00030001, 32'h0, 32'h0, 32'h0};
    mem_lines[28'h0003001] = {32'h12345003, 32'h0, 32'h0, 32'h0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(walk_req_ready), 1);
    check("rst_memvalid", 32'(mem_req_valid), 0);
    check("rst_respvalid", 32'(walk_resp_valid), 0);
    check("rst_line", 32'(mem_req_line), 0);
    check("rst_ppn", 32'(walk_resp_ppn), 0);
    check("rst_fault", 32'(walk_resp_fault), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    do_walk(20'h00403, 1'b0);
    check("t1_lat", 32'(r_t), 5);
    check("t1_ppn", 32'(r_ppn), 32'h12345);
    check("t1_fault", 32'(r_fault), 0);
    check("t1_admin", 32'(r_admin), 0);
    check("t1_reads", 32'(r_reads), 2);
    check("t1_nlines", 32'(lines_seen.size()), 2);
    if (lines_seen.size() == 2) begin
      check("t1_l1line", 32'(lines_seen[0]), 32'h0);
      check("t1_l2line", 32'(lines_seen[1]), 32'h2000);
    end

    do_walk(20'h05000, 1'b0);
    check("t2_lat", 32'(r_t), 3);
    check("t2_fault", 32'(r_fault), 1);
    check("t2_ppn", 32'(r_ppn), 0);
    check("t2_reads", 32'(r_reads), 1);

    do_walk(20'h01C07, 1'b0);
    check("t3u_fault", 32'(r_fault), 1);
    check("t3u_ppn", 32'(r_ppn), 0);
    do_walk(20'h01C07, 1'b1);
    check("t3a_fault", 32'(r_fault), 0);
    check("t3a_ppn", 32'(r_ppn), 32'h12345);
    check("t3a_admin", 32'(r_admin), 1);

    do_walk(20'h00402, 1'b0);
    check("leafv0_lat", 32'(r_t), 5);
    check("leafv0_fault", 32'(r_fault), 1);
    check("leafv0_reads", 32'(r_reads), 2);

    stall = 4;
    do_walk(20'h00403, 1'b0);
    check("t4_lat", 32'(r_t), 9);
    check("t4_ppn", 32'(r_ppn), 32'h12345);
    check("t4_nlines", 32'(lines_seen.size()), 6);
    foreach (lines_seen[i]) check("t4_line", 32'(lines_seen[i]), (i < 5) ? 32'h0 : 32'h2000);

    do_walk(20'h00403, 1'b0);
    check("t6_ppn", 32'(r_ppn), 32'h12345);
`ifdef PTW_CACHE_EN
    check("t6_hit_lat", 32'(r_t), 1);
    check("t6_hit_reads", 32'(r_reads), 0);
    check("t6_hit_memvalid", 32'(lines_seen.size()), 0);
`else
    check("t6_lat", 32'(r_t), 5);
    check("t6_reads", 32'(r_reads), 2);
`endif

    @(posedge clk); #1;
    walk_req_valid = 1'b1;
    walk_req_vpn = 20'h00403;
    walk_flush = 1'b1;
    @(negedge clk);
    check("idleflush_ready", 32'(walk_req_ready), 0);
    @(posedge clk); #1;
    walk_req_valid = 1'b0;
    walk_flush = 1'b0;
    @(negedge clk);
    check("idleflush_ready_after", 32'(walk_req_ready), 1);
    check("idleflush_memvalid", 32'(mem_req_valid), 0);

    do_walk(20'h00403, 1'b0);
    check("t6_flushed_lat", 32'(r_t), 5);
    check("t6_flushed_reads", 32'(r_reads), 2);

    base = req_count;
    stall = 3;
    @(posedge clk); #1;
    walk_req_valid = 1'b1;
    @(posedge clk); #1;
    walk_req_valid = 1'b0;
    @(posedge clk); #1;
    walk_flush = 1'b1;
    @(posedge clk); #1;
    walk_flush = 1'b0;
    stall = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (walk_resp_valid) seen++;
    end
    check("l1reqflush_resp", 32'(seen), 0);
    check("l1reqflush_ready", 32'(walk_req_ready), 1);
    check("l1reqflush_reads", 32'(req_count - base), 0);

    lat = 4;
    base = req_count;
    @(posedge clk); #1;
    walk_req_valid = 1'b1;
    walk_req_vpn = 20'h00403;
    @(posedge clk); #1;
    walk_req_valid = 1'b0;
    for (int i = 0; i < 40 && req_count < base + 2; i++) @(negedge clk);
    check("t5_l2_issued", 32'(req_count - base), 2);
    @(posedge clk); #1;
    walk_flush = 1'b1;
    @(posedge clk); #1;
    walk_flush = 1'b0;
    seen = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (walk_resp_valid) seen++;
      if (k == 3) begin
        check("t5_memresp_k3", 32'(mem_resp_valid), 1);
        check("t5_ready_k3", 32'(walk_req_ready), 0);
      end
      if (k == 4) check("t5_ready_k4", 32'(walk_req_ready), 1);
    end
    check("t5_no_resp", 32'(seen), 0);
    lat = 1;
    do_walk(20'h00403, 1'b0);
    check("t5_next_lat", 32'(r_t), 5);
    check("t5_next_ppn", 32'(r_ppn), 32'h12345);

    lat = 3;
    base = req_count;
    @(posedge clk); #1;
    walk_req_valid = 1'b1;
    walk_req_vpn = 20'h01C07;
    walk_req_admin = 1'b1;
    @(posedge clk); #1;
    walk_req_valid = 1'b0;
    for (int i = 0; i < 40 && req_count < base + 1; i++) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (walk_resp_valid) seen++;
    end
    check("rstmid_no_resp", 32'(seen), 0);
    check("rstmid_ready", 32'(walk_req_ready), 1);
    lat = 1;
    do_walk(20'h01C07, 1'b1);
    check("rstmid_next_lat", 32'(r_t), 5);
    check("rstmid_next_ppn", 32'(r_ppn), 32'h12345);
    check("rstmid_next_admin", 32'(r_admin), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
